integer_issue_scheduler: RTL and testbench

Round-robin issue scheduler sitting between the integer reservation-station slots and one integer execution lane. Each cycle it picks one operand-ready slot, latches its decoded instruction, operands, ROB index and PC into a single output register, and presents them to the lane over a valid/ready handshake. Round-robin selection keeps issue fair among slots. A ROB flush empties the output register and suppresses grants.

---
 rtl/integer_issue_scheduler.sv | 132 +++++++++++++
 tb/tb_integer_issue_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : integer_issue_scheduler
// Description : Round-robin pick of one operand-ready RS slot into a single
//               output register feeding one integer lane (valid/ready).
// Revision    : 1.0 - initial release
// ============================================================================
module integer_issue_scheduler #(
    parameter int XLEN                = 64,
    parameter int ROB_INDEX_WIDTH     = 8,
    parameter int DECODED_INSTR_WIDTH = 6,
    parameter int NUM_REQ             = 4,
    parameter int PTR_W               = $clog2(NUM_REQ)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_REQ-1:0]                     req_valid,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ*XLEN-1:0]                req_1st_reg,
    input  logic [NUM_REQ*XLEN-1:0]                req_2nd_reg,
    input  logic [NUM_REQ*DECODED_INSTR_WIDTH-1:0] req_decoded_instruction,
    input  logic [NUM_REQ*ROB_INDEX_WIDTH-1:0]     req_ROB_index,
    input  logic [NUM_REQ*XLEN-1:0]                req_PC,
    output logic                                   lane_valid,
    input  logic                                   lane_ready,
    output logic [XLEN-1:0]                        lane_1st_reg,
    output logic [XLEN-1:0]                        lane_2nd_reg,
    output logic [XLEN-1:0]                        lane_PC,
    output logic [DECODED_INSTR_WIDTH-1:0]         lane_decoded_instruction,
    output logic [ROB_INDEX_WIDTH-1:0]             lane_ROB_index,
    output logic [31:0]                            issue_count,
    input  logic                                   flush
);

    logic                           r_full;
    logic [PTR_W-1:0]               r_ptr;
    logic [31:0]                    r_count;
    logic [XLEN-1:0]                r_1st;
    logic [XLEN-1:0]                r_2nd;
    logic [XLEN-1:0]                r_pc;
    logic [DECODED_INSTR_WIDTH-1:0] r_dec;
    logic [ROB_INDEX_WIDTH-1:0]     r_rob;

    logic                           w_load_en;
    logic                           w_any;
    logic                           w_grant;
    logic [PTR_W-1:0]               w_winner;
    logic [PTR_W-1:0]               w_next_ptr;
    logic [XLEN-1:0]                w_sel_1st;
    logic [XLEN-1:0]                w_sel_2nd;
    logic [XLEN-1:0]                w_sel_pc;
    logic [DECODED_INSTR_WIDTH-1:0] w_sel_dec;
    logic [ROB_INDEX_WIDTH-1:0]     w_sel_rob;

    // Modulo-NUM_REQ wrap for values below 2*NUM_REQ; works for any NUM_REQ.
    function automatic logic [PTR_W-1:0] f_wrap(input int v);
        return (v >= NUM_REQ) ? PTR_W'(v - NUM_REQ) : PTR_W'(v);
    endfunction

    assign w_load_en  = (~r_full | lane_ready) & ~flush;
    assign w_grant    = w_load_en & w_any;
    assign w_next_ptr = f_wrap(int'(w_winner) + 1);

    // Scan from the far end back toward r_ptr so the nearest requester wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[f_wrap(int'(r_ptr) + k)]) begin
                w_any    = 1'b1;
                w_winner = f_wrap(int'(r_ptr) + k);
            end
        end
    end

    always_comb begin
        w_sel_1st = '0;
        w_sel_2nd = '0;
        w_sel_pc  = '0;
        w_sel_dec = '0;
        w_sel_rob = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_sel_1st = req_1st_reg[i*XLEN +: XLEN];
                w_sel_2nd = req_2nd_reg[i*XLEN +: XLEN];
                w_sel_pc  = req_PC[i*XLEN +: XLEN];
                w_sel_dec = req_decoded_instruction[i*DECODED_INSTR_WIDTH +: DECODED_INSTR_WIDTH];
                w_sel_rob = req_ROB_index[i*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = w_grant & req_valid[g] & (w_winner == PTR_W'(g));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_ptr   <= '0;
            r_count <= '0;
            r_1st   <= '0;
            r_2nd   <= '0;
            r_pc    <= '0;
            r_dec   <= '0;
            r_rob   <= '0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (w_load_en) begin
            r_full <= w_any;
            if (w_any) begin
                r_ptr   <= w_next_ptr;
                r_count <= r_count + 32'd1;
                r_1st   <= w_sel_1st;
                r_2nd   <= w_sel_2nd;
                r_pc    <= w_sel_pc;
                r_dec   <= w_sel_dec;
                r_rob   <= w_sel_rob;
            end
        end
    end

    assign lane_valid               = r_full;
    assign lane_1st_reg             = r_1st;
    assign lane_2nd_reg             = r_2nd;
    assign lane_PC                  = r_pc;
    assign lane_decoded_instruction = r_dec;
    assign lane_ROB_index           = r_rob;
    assign issue_count              = r_count;

endmodule
`default_nettype wire

// File: tb/tb_integer_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_integer_issue_scheduler
// Description : Directed table plus randomized model check of the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integer_issue_scheduler;

    localparam int N  = 4;
    localparam int XL = 64;
    localparam int RW = 8;
    localparam int DW = 6;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset, flush, lane_ready, lane_valid;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*XL-1:0] req_1st_reg, req_2nd_reg, req_PC;
    logic [N*DW-1:0] req_decoded_instruction;
    logic [N*RW-1:0] req_ROB_index;
    logic [XL-1:0]   lane_1st_reg, lane_2nd_reg, lane_PC;
    logic [DW-1:0]   lane_decoded_instruction;
    logic [RW-1:0]   lane_ROB_index;
    logic [31:0]     issue_count;

    logic [XL-1:0] s_a[N], s_b[N], s_pc[N];
    logic [DW-1:0] s_dec[N];
    logic [RW-1:0] s_rob[N];

    always_comb begin
        req_1st_reg = '0;
        req_2nd_reg = '0;
        req_PC = '0;
        req_decoded_instruction = '0;
        req_ROB_index = '0;
        for (int i = 0; i < N; i++) begin
            req_1st_reg[i*XL +: XL] = s_a[i];
            req_2nd_reg[i*XL +: XL] = s_b[i];
            req_PC[i*XL +: XL] = s_pc[i];
            req_decoded_instruction[i*DW +: DW] = s_dec[i];
            req_ROB_index[i*RW +: RW] = s_rob[i];
        end
    end

    integer_issue_scheduler #(
        .XLEN(XL), .ROB_INDEX_WIDTH(RW), .DECODED_INSTR_WIDTH(DW), .NUM_REQ(N)
    ) u_dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_1st_reg(req_1st_reg), .req_2nd_reg(req_2nd_reg),
        .req_decoded_instruction(req_decoded_instruction),
        .req_ROB_index(req_ROB_index), .req_PC(req_PC),
        .lane_valid(lane_valid), .lane_ready(lane_ready),
        .lane_1st_reg(lane_1st_reg), .lane_2nd_reg(lane_2nd_reg), .lane_PC(lane_PC),
        .lane_decoded_instruction(lane_decoded_instruction),
        .lane_ROB_index(lane_ROB_index), .issue_count(issue_count), .flush(flush)
    );

    // Three-slot build to exercise pointer wrap on a non-power-of-two count.
    logic        reset3, lane_ready3, lane_valid3;
    logic [2:0]  rv3, ready3;
    logic [23:0] opa3, opb3, pc3;
    logic [5:0]  dec3;
    logic [11:0] rob3;
    logic [7:0]  l1_3, l2_3, lpc3;
    logic [1:0]  ldec3;
    logic [3:0]  lrob3;
    logic [31:0] count3;

    integer_issue_scheduler #(
        .XLEN(8), .ROB_INDEX_WIDTH(4), .DECODED_INSTR_WIDTH(2), .NUM_REQ(3)
    ) u_dut3 (
        .clock(clock), .reset(reset3),
        .req_valid(rv3), .req_ready(ready3),
        .req_1st_reg(opa3), .req_2nd_reg(opb3),
        .req_decoded_instruction(dec3),
        .req_ROB_index(rob3), .req_PC(pc3),
        .lane_valid(lane_valid3), .lane_ready(lane_ready3),
        .lane_1st_reg(l1_3), .lane_2nd_reg(l2_3), .lane_PC(lpc3),
        .lane_decoded_instruction(ldec3),
        .lane_ROB_index(lrob3), .issue_count(count3), .flush(1'b0)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       fl;
        logic [3:0] rv;
        logic       lr;
        logic [3:0] ready;
        logic       valid;
        logic       chk_rob;
        logic [7:0] rob;
        int         count;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: what the output register should hold.
    logic          m_full;
    int            m_ptr;
    logic [31:0]   m_count;
    logic [XL-1:0] m_a, m_b, m_pc;
    logic [DW-1:0] m_dec;
    logic [RW-1:0] m_rob;

    function automatic int model_pick(input logic [N-1:0] rv, input int ptr);
        for (int k = 0; k < N; k++)
            if (rv[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        w = model_pick(req_valid, m_ptr);
        if (!flush && (!m_full || lane_ready) && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    task automatic model_step();
        int w;
        if (reset) begin
            m_full = 1'b0; m_ptr = 0; m_count = '0;
            m_a = '0; m_b = '0; m_pc = '0; m_dec = '0; m_rob = '0;
        end else if (flush) begin
            m_full = 1'b0;
        end else if (!m_full || lane_ready) begin
            w = model_pick(req_valid, m_ptr);
            if (w < 0) begin
                m_full = 1'b0;
            end else begin
                m_full = 1'b1;
                m_ptr = (w + 1) % N;
                m_count = m_count + 32'd1;
                m_a = s_a[w]; m_b = s_b[w]; m_pc = s_pc[w];
                m_dec = s_dec[w]; m_rob = s_rob[w];
            end
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; lane_ready = 1'b0; req_valid = '0;
        reset3 = 1'b1; lane_ready3 = 1'b0; rv3 = '0;
        opa3 = 24'h030201; opb3 = 24'h131211; pc3 = 24'h232221;
        dec3 = 6'b100100; rob3 = {4'h3, 4'h2, 4'h1};
        for (int i = 0; i < N; i++) begin
            s_a[i] = 64'hA000 + 64'(i);
            s_b[i] = 64'hB000 + 64'(i);
            s_pc[i] = 64'h1000 + 64'(i * 4);
            s_dec[i] = DW'(i + 1);
        end
        s_rob[0] = 8'h10; s_rob[1] = 8'h11; s_rob[2] = 8'h2A; s_rob[3] = 8'h13;

        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h00, 0});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 1});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 2});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h2A, 3});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h13, 4});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 5});
        tbl.push_back('{1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 8'h00, 0});
        tbl.push_back('{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 1});
        tbl.push_back('{1'b0, 1'b0, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h13, 2});
        tbl.push_back('{1'b0, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 3});
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h2A, 4});
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h2A, 4});
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h2A, 4});
        tbl.push_back('{1'b0, 1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 8'h2A, 4});
        tbl.push_back('{1'b0, 1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 5});
        tbl.push_back('{1'b0, 1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h00, 5});
        tbl.push_back('{1'b0, 1'b0, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 6});
        tbl.push_back('{1'b0, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 6});
        tbl.push_back('{1'b0, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 8'h11, 7});
        tbl.push_back('{1'b1, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 8'h00, 0});
        tbl.push_back('{1'b0, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h10, 1});

        foreach (tbl[r]) begin
            reset = tbl[r].rst; flush = tbl[r].fl;
            req_valid = tbl[r].rv; lane_ready = tbl[r].lr;
            #1;
            chk($sformatf("tbl[%0d] req_ready", r), 64'(req_ready), 64'(tbl[r].ready));
            @(posedge clock); #1;
            chk($sformatf("tbl[%0d] lane_valid", r), 64'(lane_valid), 64'(tbl[r].valid));
            chk($sformatf("tbl[%0d] issue_count", r), 64'(issue_count), 64'(tbl[r].count));
            if (tbl[r].chk_rob)
                chk($sformatf("tbl[%0d] lane_ROB_index", r), 64'(lane_ROB_index), 64'(tbl[r].rob));
        end

        // Three-slot build: grant slot 2, then all request -> slot 0 wins.
        reset3 = 1'b1; @(posedge clock); #1;
        reset3 = 1'b0; lane_ready3 = 1'b1; rv3 = 3'b100; #1;
        chk("n3 first ready", 64'(ready3), 64'(3'b100));
        @(posedge clock); #1;
        chk("n3 first rob", 64'(lrob3), 64'h3);
        rv3 = 3'b111; #1;
        chk("n3 wrap ready", 64'(ready3), 64'(3'b001));
        @(posedge clock); #1;
        chk("n3 wrap rob", 64'(lrob3), 64'h1);
        chk("n3 count", 64'(count3), 64'd2);
        rv3 = 3'b000;

        // Randomized run against the model, starting from a reset.
        reset = 1'b1; flush = 1'b0; req_valid = '0; lane_ready = 1'b0;
        model_step();
        @(posedge clock); #1;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd lane_valid", 64'(lane_valid), 64'(m_full));
            chk("rnd issue_count", 64'(issue_count), 64'(m_count));
            if (m_full) begin
                chk("rnd lane_1st_reg", lane_1st_reg, m_a);
                chk("rnd lane_2nd_reg", lane_2nd_reg, m_b);
                chk("rnd lane_PC", lane_PC, m_pc);
                chk("rnd lane_decoded", 64'(lane_decoded_instruction), 64'(m_dec));
                chk("rnd lane_ROB_index", 64'(lane_ROB_index), 64'(m_rob));
            end
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 15) == 0);
            req_valid = N'($urandom);
            lane_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                s_a[i] = {$urandom, $urandom};
                s_b[i] = {$urandom, $urandom};
                s_pc[i] = {$urandom, $urandom};
                s_dec[i] = DW'($urandom);
                s_rob[i] = RW'($urandom);
            end
            #1;
            chk("rnd req_ready", 64'(req_ready), 64'(model_ready()));
            model_step();
            @(posedge clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
